// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: ctrl/exu redirect inputs, ROM port and IF/ID handoff signals.
// slave = the fetch unit, master = the surrounding pipeline/ROM.
interface ifu_fetch_if;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        ctrl_redirect_pc_i;
    logic [31:0] ctrl_redirect_addr_i;
    logic        branch_redirect_i;
    logic [31:0] branch_redirect_addr_i;
    logic [31:0] inst_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] pc_o;
    logic [31:0] next_pc_o;
    logic        next_taken_o;
    logic        branch_slot_end_o;

    modport slave (
        input  stall_i, flush_i, ctrl_redirect_pc_i, ctrl_redirect_addr_i,
               branch_redirect_i, branch_redirect_addr_i, inst_i,
        output rom_ce_o, rom_addr_o, pc_o, next_pc_o, next_taken_o, branch_slot_end_o
    );

    modport master (
        output stall_i, flush_i, ctrl_redirect_pc_i, ctrl_redirect_addr_i,
               branch_redirect_i, branch_redirect_addr_i, inst_i,
        input  rom_ce_o, rom_addr_o, pc_o, next_pc_o, next_taken_o, branch_slot_end_o
    );
endinterface

// File: rtl/ifu_fetch.sv
// Fetch PC owner: sequential PC, ctrl/branch redirects and post-branch drain window.
// Optional macro IFU_STATIC_BPU_EN enables static predecode (JAL, backward branches).
module ifu_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          BRANCH_SLOTS = 2
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    ifu_fetch_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic [31:0] next_pc_s;
    logic        next_taken_s;
    logic        slot_end_s;

    // State register: PC, FSM state, drain counter and ROM enable
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            pc_q    <= RESET_PC;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ce_q    <= ce_d;
        end
    end

    // Next-state logic: redirect priority, then RUN advance / DRAIN countdown
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        ce_d    = 1'b1;
        if (bus.flush_i || bus.ctrl_redirect_pc_i) begin
            pc_d    = {bus.ctrl_redirect_addr_i[31:2], 2'b00};
            state_d = ST_RUN;
            cnt_d   = 4'd0;
        end else if (bus.branch_redirect_i) begin
            pc_d    = {bus.branch_redirect_addr_i[31:2], 2'b00};
            state_d = ST_DRAIN;
            cnt_d   = 4'(BRANCH_SLOTS - 1);
        end else begin
            case (state_q)
                ST_RUN: begin
                    // PC only advances once the ROM is enabled, so RESET_PC is fetched
                    if (ce_q && !bus.stall_i[0]) begin
                        pc_d = next_pc_s;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Output logic: prediction and drain-window pulse
    always_comb begin
        next_pc_s    = pc_q + 32'd4;
        next_taken_s = 1'b0;
`ifdef IFU_STATIC_BPU_EN
        if (ce_q) begin
            if (bus.inst_i[6:0] == 7'b1101111) begin
                next_pc_s    = pc_q + {{11{bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[19:12],
                                       bus.inst_i[20], bus.inst_i[30:21], 1'b0};
                next_taken_s = 1'b1;
            end else if ((bus.inst_i[6:0] == 7'b1100011) && bus.inst_i[31]) begin
                next_pc_s    = pc_q + {{19{bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[7],
                                       bus.inst_i[30:25], bus.inst_i[11:8], 1'b0};
                next_taken_s = 1'b1;
            end else begin
                next_pc_s    = pc_q + 32'd4;
                next_taken_s = 1'b0;
            end
        end else begin
            next_pc_s    = pc_q + 32'd4;
            next_taken_s = 1'b0;
        end
`endif
        slot_end_s = (state_q == ST_DRAIN) && (cnt_q == 4'd0);
    end

    assign bus.rom_ce_o          = ce_q;
    assign bus.rom_addr_o        = pc_q;
    assign bus.pc_o              = pc_q;
    assign bus.next_pc_o         = next_pc_s;
    assign bus.next_taken_o      = next_taken_s;
    assign bus.branch_slot_end_o = slot_end_s;

endmodule
